// File: rtl/rob_retire_queue_if.sv
// Packet types and the dispatch / CDB / retire bundle shared by the reorder buffer and its neighbours.
package rob_retire_queue_pkg;
  localparam int PREG_BITS = 6;
  localparam int AREG_BITS = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [PREG_BITS-1:0] T_new;
    logic [PREG_BITS-1:0] T_old;
    logic [AREG_BITS-1:0] arch_reg;
    logic                 halt;
    logic                 illegal;
    logic [XLEN-1:0]      NPC;
  } rob_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [PREG_BITS-1:0] completing_reg;
  } cdb_etb_packet_t;
endpackage

interface rob_retire_queue_if #(
  parameter int N               = 3,
  parameter int ROB_SZ          = 32,
  parameter int ROB_SZ_BITS     = $clog2(ROB_SZ),
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
);
  logic [NUM_SCALAR_BITS-1:0]                     num_dispatched;
  rob_retire_queue_pkg::rob_packet_t [N-1:0]     rob_entries;
  rob_retire_queue_pkg::cdb_etb_packet_t [N-1:0] cdb_completing;
  logic                                          restore_valid;
  logic [ROB_SZ_BITS-1:0]                        restore_rob_tail;
  logic [ROB_SZ_BITS-1:0]                        rob_tail;
  logic [NUM_SCALAR_BITS-1:0]                    rob_spots;
  logic [NUM_SCALAR_BITS-1:0]                    num_retiring;
  rob_retire_queue_pkg::rob_packet_t [N-1:0]     retire_entries;
  logic                                          halt_retired;
  logic                                          illegal_retired;

  modport master (
    output num_dispatched, rob_entries, cdb_completing, restore_valid, restore_rob_tail,
    input  rob_tail, rob_spots, num_retiring, retire_entries, halt_retired, illegal_retired
  );

  modport slave (
    input  num_dispatched, rob_entries, cdb_completing, restore_valid, restore_rob_tail,
    output rob_tail, rob_spots, num_retiring, retire_entries, halt_retired, illegal_retired
  );
endinterface

// File: rtl/rob_retire_queue.sv
// In-order reorder buffer: accepts up to N entries per cycle, completes them from the CDB,
// retires up to N oldest completed entries and truncates its tail on mispredict recovery.
module rob_retire_queue #(
  parameter int N               = 3,
  parameter int ROB_SZ          = 32,
  parameter int ROB_SZ_BITS     = $clog2(ROB_SZ),
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic              clock,
  input  logic              reset,
  rob_retire_queue_if.slave rob
);
  import rob_retire_queue_pkg::*;

  typedef enum logic {RUN, HALTED} state_e;

  state_e                     state_q;
  logic [ROB_SZ_BITS-1:0]     head_q, head_d, tail_q, tail_d;
  logic [ROB_SZ_BITS:0]       count_q, count_d, free_slots;
  logic [ROB_SZ-1:0]          complete_q, complete_d, disp_mask;
  rob_packet_t                entries_q [ROB_SZ];
  logic                       halt_retired_q, illegal_retired_q;
  logic [NUM_SCALAR_BITS-1:0] num_disp, num_ret;
  rob_packet_t [N-1:0]        ret_lanes;
  logic                       ret_halt, ret_illegal;

  // Retire group: consecutive completed entries from head, cut after a halt/illegal entry.
  always_comb begin : retire_select
    logic                   stop;
    logic [ROB_SZ_BITS-1:0] idx;
    num_ret     = '0;
    ret_lanes   = '0;
    ret_halt    = 1'b0;
    ret_illegal = 1'b0;
    stop        = (state_q == HALTED);
    for (int i = 0; i < N; i++) begin
      idx = head_q + ROB_SZ_BITS'(i);
      if (!stop && ((ROB_SZ_BITS+1)'(i) < count_q) && complete_q[idx]) begin
        ret_lanes[i] = entries_q[idx];
        num_ret      = num_ret + NUM_SCALAR_BITS'(1);
        ret_halt     = ret_halt | entries_q[idx].halt;
        ret_illegal  = ret_illegal | entries_q[idx].illegal;
        if (entries_q[idx].halt || entries_q[idx].illegal) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign num_disp = rob.restore_valid ? '0 : rob.num_dispatched;
  assign head_d   = head_q + ROB_SZ_BITS'(num_ret);

  always_comb begin
    if (rob.restore_valid) begin
      tail_d  = rob.restore_rob_tail;
      count_d = {1'b0, rob.restore_rob_tail - head_d};
    end else begin
      tail_d  = tail_q + ROB_SZ_BITS'(num_disp);
      count_d = count_q + (ROB_SZ_BITS+1)'(num_disp) - (ROB_SZ_BITS+1)'(num_ret);
    end
  end

  always_comb begin
    disp_mask = '0;
    for (int i = 0; i < N; i++)
      if (NUM_SCALAR_BITS'(i) < num_disp) disp_mask[tail_q + ROB_SZ_BITS'(i)] = 1'b1;
  end

  // Bits outside the next occupied window are forced low, which covers retire and restore discard.
  for (genvar gi = 0; gi < ROB_SZ; gi++) begin : g_complete
    logic [ROB_SZ_BITS-1:0] off_q, off_d;
    logic                   hit;
    assign off_q = ROB_SZ_BITS'(gi) - head_q;
    assign off_d = ROB_SZ_BITS'(gi) - head_d;
    always_comb begin
      hit = 1'b0;
      for (int c = 0; c < N; c++)
        if (rob.cdb_completing[c].valid &&
            entries_q[gi].T_new == rob.cdb_completing[c].completing_reg) hit = 1'b1;
    end
    assign complete_d[gi] = ({1'b0, off_d} < count_d) && !disp_mask[gi] &&
                            (complete_q[gi] || (hit && ({1'b0, off_q} < count_q)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= RUN;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      complete_q        <= '0;
      halt_retired_q    <= 1'b0;
      illegal_retired_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      if (ret_halt) halt_retired_q <= 1'b1;
      if (ret_illegal) illegal_retired_q <= 1'b1;
      if (ret_halt || ret_illegal) state_q <= HALTED;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        if (NUM_SCALAR_BITS'(i) < num_disp) entries_q[tail_q + ROB_SZ_BITS'(i)] <= rob.rob_entries[i];
    end
  end

  assign free_slots          = (ROB_SZ_BITS+1)'(ROB_SZ) - count_q;
  assign rob.rob_tail        = tail_q;
  assign rob.rob_spots       = (free_slots > (ROB_SZ_BITS+1)'(N)) ? NUM_SCALAR_BITS'(N)
                                                                  : NUM_SCALAR_BITS'(free_slots);
  assign rob.num_retiring    = num_ret;
  assign rob.retire_entries  = ret_lanes;
  assign rob.halt_retired    = halt_retired_q;
  assign rob.illegal_retired = illegal_retired_q;
endmodule

// File: tb/tb_rob_retire_queue.sv
// Bench for rob_retire_queue (N=3, ROB_SZ=8): directed vector table, hand sequences, and random traffic vs a queue model.
module tb_rob_retire_queue;
  import rob_retire_queue_pkg::*;

  localparam int N  = 3;
  localparam int SZ = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rob_retire_queue_if #(.N(N), .ROB_SZ(SZ)) ifc ();
  rob_retire_queue #(.N(N), .ROB_SZ(SZ)) dut (.clock(clock), .reset(reset), .rob(ifc));

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  // Reference model: the occupied window as a queue, oldest first.
  rob_packet_t mq_pkt[$];
  bit          mq_done[$];
  int          m_head, m_tail;
  bit          m_halted, m_hr, m_ir;

  typedef struct {
    int              nd;
    logic [2:0][5:0] t;
    logic [2:0]      hm;
    logic [2:0]      cm;
    logic [2:0][5:0] c;
    bit              rv;
    int              rt;
    int              e_tail, e_spots, e_nr;
    logic [2:0][5:0] e_l;
    bit              e_hr;
  } vec_t;
  vec_t vecs[$];

  function automatic rob_packet_t mk(input logic [5:0] t, input bit h, input bit il);
    rob_packet_t p;
    p.T_new    = t;
    p.T_old    = t ^ 6'h2a;
    p.arch_reg = t[4:0] + 5'd1;
    p.halt     = h;
    p.illegal  = il;
    p.NPC      = 32'h1000 + {24'd0, t, 2'b00};
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_no, act, exp);
    end
  endtask

  function automatic int model_nr();
    int k;
    k = 0;
    if (m_halted) return 0;
    while (k < N && k < mq_pkt.size() && mq_done[k]) begin
      k++;
      if (mq_pkt[k-1].halt || mq_pkt[k-1].illegal) break;
    end
    return k;
  endfunction

  function automatic int model_spots();
    int f;
    f = SZ - mq_pkt.size();
    return (f < N) ? f : N;
  endfunction

  task automatic model_reset();
    mq_pkt.delete();
    mq_done.delete();
    m_head = 0; m_tail = 0; m_halted = 0; m_hr = 0; m_ir = 0;
  endtask

  task automatic check_model();
    int k;
    rob_packet_t e;
    k = model_nr();
    chk("m_tail", ifc.rob_tail, m_tail);
    chk("m_spots", ifc.rob_spots, model_spots());
    chk("m_nr", ifc.num_retiring, k);
    for (int i = 0; i < N; i++) begin
      e = '0;
      if (i < k) e = mq_pkt[i];
      chk($sformatf("m_lane%0d", i), ifc.retire_entries[i], e);
    end
    chk("m_halt", ifc.halt_retired, m_hr);
    chk("m_illegal", ifc.illegal_retired, m_ir);
  endtask

  // Applies the edge to the model using the inputs the bench is driving.
  task automatic model_update();
    int k, nc;
    k = model_nr();
    for (int c = 0; c < N; c++)
      if (ifc.cdb_completing[c].valid)
        for (int j = 0; j < mq_pkt.size(); j++)
          if (mq_pkt[j].T_new == ifc.cdb_completing[c].completing_reg) mq_done[j] = 1'b1;
    for (int i = 0; i < k; i++) begin
      if (mq_pkt[0].halt)    begin m_hr = 1; m_halted = 1; end
      if (mq_pkt[0].illegal) begin m_ir = 1; m_halted = 1; end
      void'(mq_pkt.pop_front());
      void'(mq_done.pop_front());
    end
    m_head = (m_head + k) % SZ;
    if (ifc.restore_valid) begin
      nc = (int'(ifc.restore_rob_tail) - m_head + SZ) % SZ;
      while (mq_pkt.size() > nc) begin
        void'(mq_pkt.pop_back());
        void'(mq_done.pop_back());
      end
      m_tail = int'(ifc.restore_rob_tail);
    end else begin
      for (int i = 0; i < int'(ifc.num_dispatched); i++) begin
        mq_pkt.push_back(ifc.rob_entries[i]);
        mq_done.push_back(1'b0);
      end
      m_tail = (m_tail + int'(ifc.num_dispatched)) % SZ;
    end
  endtask

  task automatic drive(input int nd, input logic [5:0] t0, t1, t2, input logic [2:0] hm, im, cm,
                       input logic [5:0] c0, c1, c2, input bit rv, input int rt);
    ifc.num_dispatched   = nd[1:0];
    ifc.rob_entries[0]   = mk(t0, hm[0], im[0]);
    ifc.rob_entries[1]   = mk(t1, hm[1], im[1]);
    ifc.rob_entries[2]   = mk(t2, hm[2], im[2]);
    ifc.cdb_completing[0] = {cm[0], c0};
    ifc.cdb_completing[1] = {cm[1], c1};
    ifc.cdb_completing[2] = {cm[2], c2};
    ifc.restore_valid    = rv;
    ifc.restore_rob_tail = rt[2:0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'b0, 3'b0, 3'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic tick();
    @(negedge clock);
    cyc_no++;
    check_model();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tail"}, ifc.rob_tail, 0);
    chk({tag, "_spots"}, ifc.rob_spots, 3);
    chk({tag, "_nr"}, ifc.num_retiring, 0);
    chk({tag, "_lanes"}, ifc.retire_entries, 0);
    chk({tag, "_halt"}, ifc.halt_retired, 0);
    chk({tag, "_illegal"}, ifc.illegal_retired, 0);
  endtask

  task automatic add(input int nd, input logic [5:0] t0, t1, t2, input logic [2:0] hm, cm,
                     input logic [5:0] c0, c1, c2, input bit rv, input int rt,
                     input int e_tail, e_spots, e_nr, input logic [5:0] l0, l1, l2, input bit e_hr);
    vec_t v;
    v.nd = nd; v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.hm = hm; v.cm = cm;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.rv = rv; v.rt = rt;
    v.e_tail = e_tail; v.e_spots = e_spots; v.e_nr = e_nr;
    v.e_l[0] = l0; v.e_l[1] = l1; v.e_l[2] = l2; v.e_hr = e_hr;
    vecs.push_back(v);
  endtask

  initial begin
    // nd  t0 t1 t2  hm     cm      c0 c1 c2  rv rt | tail spots nr  l0 l1 l2  hr
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   0, 3, 0,  0, 0, 0,  0);
    add(3, 33,34,35, 3'b000, 3'b000, 0, 0, 0,  0, 0,   0, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b011, 34,35,0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b001, 33,0, 0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 3,  33,34,35, 0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(3, 1, 2, 3,  3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(3, 4, 5, 6,  3'b000, 3'b000, 0, 0, 0,  0, 0,   6, 3, 0,  0, 0, 0,  0);
    add(2, 7, 8, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   1, 2, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b111, 1, 2, 3,  0, 0,   3, 0, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b111, 4, 5, 6,  0, 0,   3, 0, 3,  1, 2, 3,  0);
    add(0, 0, 0, 0,  3'b000, 3'b011, 7, 8, 0,  0, 0,   3, 3, 3,  4, 5, 6,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 2,  7, 8, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(3, 10,11,12, 3'b000, 3'b000, 0, 0, 0,  0, 0,   3, 3, 0,  0, 0, 0,  0);
    add(2, 13,14,0,  3'b000, 3'b001, 10,0, 0,  0, 0,   6, 3, 0,  0, 0, 0,  0);
    add(2, 50,51,0,  3'b000, 3'b001, 12,0, 0,  1, 5,   0, 3, 1,  10,0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   5, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b001, 11,0, 0,  0, 0,   5, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   5, 3, 1,  11,0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   5, 3, 0,  0, 0, 0,  0);
    add(3, 20,21,22, 3'b010, 3'b000, 0, 0, 0,  0, 0,   5, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b111, 20,21,22, 0, 0,   0, 3, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   0, 3, 2,  20,21,0,  0);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   0, 3, 0,  0, 0, 0,  1);
    add(0, 0, 0, 0,  3'b000, 3'b001, 22,0, 0,  0, 0,   0, 3, 0,  0, 0, 0,  1);
    add(0, 0, 0, 0,  3'b000, 3'b000, 0, 0, 0,  0, 0,   0, 3, 0,  0, 0, 0,  1);

    do_reset();
    check_reset("rst0");

    foreach (vecs[r]) begin
      drive(vecs[r].nd, vecs[r].t[0], vecs[r].t[1], vecs[r].t[2], vecs[r].hm, 3'b000, vecs[r].cm,
            vecs[r].c[0], vecs[r].c[1], vecs[r].c[2], vecs[r].rv, vecs[r].rt);
      chk($sformatf("v%0d_tail", r), ifc.rob_tail, vecs[r].e_tail);
      chk($sformatf("v%0d_spots", r), ifc.rob_spots, vecs[r].e_spots);
      chk($sformatf("v%0d_nr", r), ifc.num_retiring, vecs[r].e_nr);
      for (int i = 0; i < N; i++) begin
        if (i < vecs[r].e_nr) chk($sformatf("v%0d_lane%0d", r, i), ifc.retire_entries[i].T_new, vecs[r].e_l[i]);
        else                  chk($sformatf("v%0d_lane%0d", r, i), ifc.retire_entries[i], 0);
      end
      chk($sformatf("v%0d_halt", r), ifc.halt_retired, vecs[r].e_hr);
      chk($sformatf("v%0d_illegal", r), ifc.illegal_retired, 0);
      tick();
    end

    // Reset must win over dispatch, CDB and restore in the same cycle, with 6 entries in flight.
    do_reset();
    drive(3, 60, 61, 62, 3'b0, 3'b0, 3'b0, 0, 0, 0, 1'b0, 0);
    tick();
    drive(3, 63, 64, 65, 3'b0, 3'b0, 3'b0, 0, 0, 0, 1'b0, 0);
    tick();
    chk("inflight_tail", ifc.rob_tail, 6);
    chk("inflight_spots", ifc.rob_spots, 2);
    drive(2, 66, 67, 0, 3'b0, 3'b0, 3'b001, 60, 0, 0, 1'b1, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    idle();
    check_reset("rst_ovr");
    tick();
    chk("rst_ovr_tail2", ifc.rob_tail, 0);

    // Illegal instruction retires alone and freezes retirement.
    drive(2, 40, 41, 0, 3'b0, 3'b001, 3'b0, 0, 0, 0, 1'b0, 0);
    tick();
    drive(0, 0, 0, 0, 3'b0, 3'b0, 3'b011, 40, 41, 0, 1'b0, 0);
    tick();
    idle();
    chk("ill_nr", ifc.num_retiring, 1);
    chk("ill_lane0", ifc.retire_entries[0].T_new, 40);
    tick();
    chk("ill_flag", ifc.illegal_retired, 1);
    chk("ill_halt", ifc.halt_retired, 0);
    chk("ill_frozen", ifc.num_retiring, 0);
    tick();

    // Random traffic with restores, checked every cycle against the queue model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int k, sz, nd, rt, off;
      bit rv;
      logic [2:0] cm;
      logic [5:0] tt [3];
      logic [5:0] cc [3];
      k   = model_nr();
      sz  = mq_pkt.size();
      rv  = ($urandom_range(0, 9) == 0);
      off = $urandom_range(0, sz - k);
      if (off > SZ - 1) off = SZ - 1;
      rt  = (m_head + k + off) % SZ;
      nd  = $urandom_range(0, model_spots());
      for (int i = 0; i < N; i++) begin
        tt[i] = 6'($urandom_range(0, 63));
        cm[i] = 1'($urandom_range(0, 1));
        if (sz > 0 && $urandom_range(0, 3) != 0) cc[i] = mq_pkt[$urandom_range(0, sz - 1)].T_new;
        else                                     cc[i] = 6'($urandom_range(0, 63));
      end
      drive(nd, tt[0], tt[1], tt[2], 3'b0, 3'b0, cm, cc[0], cc[1], cc[2], rv, rt);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
